// File: rtl/fp_norm_seq_if.sv
//------------------------------------------------------------------------------
// fp_norm_seq_if : operand/result handshake bundle for the sequential normalizer
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface fp_norm_seq_if #(
  parameter int SIZE_EXP = 8,
  parameter int SIZE_MAN = 23
);
  logic                  i_valid;
  logic                  o_ready;
  logic                  i_sign;
  logic [SIZE_EXP-1:0]   i_exp;
  logic [SIZE_MAN+1:0]   i_mant;
  logic                  o_valid;
  logic                  i_ready;
  logic                  o_sign;
  logic [SIZE_EXP-1:0]   o_exp;
  logic [SIZE_MAN-1:0]   o_mant;
  logic                  o_zero;
  logic                  o_overflow;
  logic                  o_underflow;
  logic                  o_inexact;

  modport slave (
    input  i_valid, i_sign, i_exp, i_mant, i_ready,
    output o_ready, o_valid, o_sign, o_exp, o_mant,
           o_zero, o_overflow, o_underflow, o_inexact
  );

  modport master (
    output i_valid, i_sign, i_exp, i_mant, i_ready,
    input  o_ready, o_valid, o_sign, o_exp, o_mant,
           o_zero, o_overflow, o_underflow, o_inexact
  );
endinterface

`default_nettype wire

// File: rtl/fp_norm_seq.sv
//------------------------------------------------------------------------------
// fp_norm_seq : one-bit-per-cycle normalizer for an unnormalized FP sum
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module fp_norm_seq #(
  parameter int SIZE_EXP = 8,
  parameter int SIZE_MAN = 23
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  fp_norm_seq_if.slave  bus
);

  localparam int MW = SIZE_MAN + 2;
  localparam int CW = $clog2(SIZE_MAN + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  localparam logic [SIZE_EXP-1:0] c_one       = SIZE_EXP'(1);
  localparam logic [SIZE_EXP-1:0] c_exp_ones  = {SIZE_EXP{1'b1}};
  localparam logic [CW-1:0]       c_max_shift = CW'(SIZE_MAN);

  logic [1:0]          r_state;
  logic                r_sign;
  logic [SIZE_EXP-1:0] r_exp;
  logic [MW-1:0]       r_mant;
  logic [CW-1:0]       r_cnt;
  logic                r_zero;
  logic                r_ovf;
  logic                r_unf;
  logic                r_inx;

  logic [SIZE_EXP-1:0] w_exp_inc;
  logic [SIZE_EXP-1:0] w_exp_dec;
  logic                w_exp_le1;
  logic [MW-1:0]       w_mant_shr;
  logic [MW-1:0]       w_mant_shl;

  assign w_exp_inc  = r_exp + c_one;
  assign w_exp_dec  = r_exp + ~c_one + c_one;
  assign w_exp_le1  = (r_exp <= c_one);
  assign w_mant_shr = r_mant >> 1;
  assign w_mant_shl = r_mant << 1;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
      r_sign  <= 1'b0;
      r_exp   <= '0;
      r_mant  <= '0;
      r_cnt   <= '0;
      r_zero  <= 1'b0;
      r_ovf   <= 1'b0;
      r_unf   <= 1'b0;
      r_inx   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.i_valid) begin
            r_sign <= bus.i_sign;
            r_exp  <= bus.i_exp;
            r_mant <= bus.i_mant;
            r_cnt  <= '0;
            r_zero <= 1'b0;
            r_ovf  <= 1'b0;
            r_unf  <= 1'b0;
            r_inx  <= 1'b0;
            if (bus.i_mant == '0) begin
              r_exp   <= '0;
              r_zero  <= 1'b1;
              r_state <= S_DONE;
            end else if (bus.i_exp == c_exp_ones) begin
              r_state <= S_DONE;
            end else begin
              r_state <= S_SHIFT;
            end
          end
        end

        S_SHIFT: begin
          if (r_mant[MW-1]) begin
            r_inx   <= r_mant[0];
            r_state <= S_DONE;
            // Carry pushed the exponent into the Inf encoding: saturate.
            if (w_exp_inc == c_exp_ones) begin
              r_exp  <= c_exp_ones;
              r_mant <= '0;
              r_ovf  <= 1'b1;
            end else begin
              r_exp  <= w_exp_inc;
              r_mant <= w_mant_shr;
            end
          end else if (r_mant[MW-2]) begin
            r_state <= S_DONE;
          end else if (w_exp_le1) begin
            r_exp   <= '0;
            r_unf   <= 1'b1;
            r_state <= S_DONE;
          end else if (r_cnt == c_max_shift) begin
            r_state <= S_DONE;
          end else begin
            r_exp  <= w_exp_dec;
            r_mant <= w_mant_shl;
            r_cnt  <= r_cnt + CW'(1);
          end
        end

        S_DONE: begin
          if (bus.i_ready) begin
            r_state <= S_IDLE;
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.o_ready     = (r_state == S_IDLE);
  assign bus.o_valid     = (r_state == S_DONE);
  assign bus.o_sign      = r_sign;
  assign bus.o_exp       = r_exp;
  assign bus.o_mant      = r_mant[SIZE_MAN-1:0];
  assign bus.o_zero      = r_zero;
  assign bus.o_overflow  = r_ovf;
  assign bus.o_underflow = r_unf;
  assign bus.o_inexact   = r_inx;

endmodule

`default_nettype wire

// File: tb/tb_fp_norm_seq.sv
//------------------------------------------------------------------------------
// tb_fp_norm_seq : directed self-checking bench for fp_norm_seq
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_fp_norm_seq;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fp_norm_seq_if #(.SIZE_EXP(8), .SIZE_MAN(23)) bus ();

  fp_norm_seq #(.SIZE_EXP(8), .SIZE_MAN(23)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Present one operand, return cycles from the accept edge until o_valid.
  task automatic send(input logic s, input logic [7:0] e, input logic [24:0] m, output int lat);
    int guard;
    guard = 0;
    while (bus.o_ready !== 1'b1 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    bus.i_valid = 1'b1;
    bus.i_sign  = s;
    bus.i_exp   = e;
    bus.i_mant  = m;
    @(posedge clk);
    @(negedge clk);
    bus.i_valid = 1'b0;
    lat = 0;
    while (bus.o_valid !== 1'b1 && lat < 100) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic check_res(input string tag, input int lat, input int exp_lat,
                           input logic s, input logic [7:0] e, input logic [22:0] m,
                           input logic z, input logic ov, input logic un, input logic ix);
    check({tag, "_lat"},  32'(lat), 32'(exp_lat));
    check({tag, "_sign"}, bus.o_sign, s);
    check({tag, "_exp"},  bus.o_exp, e);
    check({tag, "_mant"}, bus.o_mant, m);
    check({tag, "_flags"},
          {bus.o_zero, bus.o_overflow, bus.o_underflow, bus.o_inexact},
          {z, ov, un, ix});
  endtask

  task automatic consume(input string tag);
    bus.i_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.i_ready = 1'b0;
    check({tag, "_idle_ready"}, bus.o_ready, 1'b1);
    check({tag, "_idle_valid"}, bus.o_valid, 1'b0);
  endtask

  initial begin
    int lat;
    bus.i_valid = 1'b0;
    bus.i_sign  = 1'b0;
    bus.i_exp   = '0;
    bus.i_mant  = '0;
    bus.i_ready = 1'b0;

    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_ready", bus.o_ready, 1'b1);
    check("rst_valid", bus.o_valid, 1'b0);
    check("rst_data", {bus.o_sign, bus.o_exp, bus.o_mant}, 32'h0);
    check("rst_flags", {bus.o_zero, bus.o_overflow, bus.o_underflow, bus.o_inexact}, 4'h0);

    // Carry: 0x1800001 >> 1 = 0xC00000, dropped LSB sets inexact
    send(1'b0, 8'h80, 25'h1800001, lat);
    check_res("carry", lat, 1, 1'b0, 8'h81, 23'h400000, 1'b0, 1'b0, 1'b0, 1'b1);
    consume("carry");

    // Already normal, sign passes through
    send(1'b1, 8'h7F, 25'h0A00000, lat);
    check_res("normal", lat, 1, 1'b1, 8'h7F, 23'h200000, 1'b0, 1'b0, 1'b0, 1'b0);
    consume("normal");

    // Three left shifts: bit 20 -> bit 23, exp 0x10 -> 0x0D
    send(1'b0, 8'h10, 25'h0100000, lat);
    check_res("shift3", lat, 4, 1'b0, 8'h0D, 23'h000000, 1'b0, 1'b0, 1'b0, 1'b0);
    consume("shift3");

    // Maximum shift: 23 left shifts, 0x80 - 23 = 0x69
    send(1'b0, 8'h80, 25'h0000001, lat);
    check_res("maxshift", lat, 24, 1'b0, 8'h69, 23'h000000, 1'b0, 1'b0, 1'b0, 1'b0);
    consume("maxshift");

    // Underflow: one shift to exp 1, then denormal with exp 0
    send(1'b0, 8'h02, 25'h0100000, lat);
    check_res("underflow", lat, 2, 1'b0, 8'h00, 23'h200000, 1'b0, 1'b0, 1'b1, 1'b0);
    consume("underflow");

    // Overflow: carry with exp 0xFE saturates to Inf
    send(1'b1, 8'hFE, 25'h1800000, lat);
    check_res("overflow", lat, 1, 1'b1, 8'hFF, 23'h000000, 1'b0, 1'b1, 1'b0, 1'b0);
    consume("overflow");

    // Inf/NaN passes straight through, flags cleared from previous result
    send(1'b0, 8'hFF, 25'h0812345, lat);
    check_res("infnan", lat, 0, 1'b0, 8'hFF, 23'h012345, 1'b0, 1'b0, 1'b0, 1'b0);
    consume("infnan");

    // Zero with stalled downstream and a competing operand that must be ignored
    send(1'b1, 8'h55, 25'h0000000, lat);
    check_res("zero", lat, 0, 1'b1, 8'h00, 23'h000000, 1'b1, 1'b0, 1'b0, 1'b0);
    bus.i_valid = 1'b1;
    bus.i_sign  = 1'b0;
    bus.i_exp   = 8'h33;
    bus.i_mant  = 25'h0C00000;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("zero_hold_valid", bus.o_valid, 1'b1);
      check("zero_hold_ready", bus.o_ready, 1'b0);
      check("zero_hold_data", {bus.o_zero, bus.o_sign, bus.o_exp, bus.o_mant},
            {1'b1, 1'b1, 8'h00, 23'h000000});
    end
    bus.i_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.i_ready = 1'b0;
    bus.i_valid = 1'b0;
    check("zero_release_ready", bus.o_ready, 1'b1);
    check("zero_release_valid", bus.o_valid, 1'b0);
    check("zero_no_accept_exp", bus.o_exp, 8'h00);

    // Reset in the middle of a long shift sequence
    bus.i_valid = 1'b1;
    bus.i_sign  = 1'b1;
    bus.i_exp   = 8'h80;
    bus.i_mant  = 25'h0000001;
    @(posedge clk);
    @(negedge clk);
    bus.i_valid = 1'b0;
    repeat (5) @(negedge clk);
    check("midshift_not_valid", bus.o_valid, 1'b0);
    rst_n = 1'b0;
    #1;
    check("midrst_valid", bus.o_valid, 1'b0);
    check("midrst_data", {bus.o_sign, bus.o_exp, bus.o_mant}, 32'h0);
    check("midrst_flags", {bus.o_zero, bus.o_overflow, bus.o_underflow, bus.o_inexact}, 4'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("midrst_ready", bus.o_ready, 1'b1);
    send(1'b0, 8'h80, 25'h1800001, lat);
    check_res("postrst", lat, 1, 1'b0, 8'h81, 23'h400000, 1'b0, 1'b0, 1'b0, 1'b1);
    consume("postrst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/fp_norm_seq.md
FP_NORM_SEQ -- requirements
Module: fp_norm_seq

Interface
REQ-001 Parameter SIZE_EXP, default 8: exponent width.
REQ-002 Parameter SIZE_MAN, default 23: stored fraction width; the internal mantissa is SIZE_MAN+2 bits (carry bit, hidden bit, fraction).
REQ-003 i_clk  input  1  the single clock; all state updates on the rising edge.
REQ-004 i_rst_n  input  1  asynchronous active-low reset.
REQ-005 i_valid  input  1  upstream presents an operand.
REQ-006 o_ready  output  1  block can accept an operand.
REQ-007 i_sign  input  1  sign; passed through unchanged.
REQ-008 i_exp  input  SIZE_EXP  biased exponent of the unnormalized sum.
REQ-009 i_mant  input  SIZE_MAN+2  unnormalized mantissa; bit 24 is carry, bit 23 is hidden.
REQ-010 o_valid  output  1  result is held stable.
REQ-011 i_ready  input  1  downstream consumes the result.
REQ-012 o_sign, o_exp[SIZE_EXP], o_mant[SIZE_MAN]  output  normalized result, with the hidden bit dropped.
REQ-013 o_zero, o_overflow, o_underflow, o_inexact  output  1 each  result flags.

Function
REQ-014 The FSM SHALL have three states: IDLE, SHIFT and DONE.
REQ-015 o_ready SHALL be 1 only in IDLE.
REQ-016 In IDLE, an operand SHALL be accepted when i_valid=1, loading the sign, exponent and mantissa registers.
REQ-017 On acceptance, the next state SHALL be DONE with o_zero=1 and o_exp=0 if i_mant==0, and SHIFT otherwise.
REQ-018 On acceptance, the next state SHALL be DONE with exponent and mantissa passed through if i_exp is all ones (Inf/NaN).
REQ-019 In SHIFT, exactly one of the following SHALL apply per cycle, in priority order:
 a) mant[24]=1: shift right by 1, exp+1, set o_inexact if the dropped bit is 1, go to DONE. If exp+1 equals all ones: o_exp=all ones, o_mant=0, o_overflow=1.
 b) mant[23]=1: go to DONE unchanged.
 c) exp<=1: go to DONE with o_exp=0, fraction unchanged, o_underflow=1 (denormal).
 d) otherwise: shift left by 1, exp-1, stay in SHIFT.
REQ-020 Exponent decrement SHALL be computed as two's-complement addition (exp + ~1 + 1); no result SHALL wrap below 0.
REQ-021 At most SIZE_MAN consecutive left shifts SHALL occur.
REQ-022 In DONE, o_valid=1 and all outputs SHALL be held stable until i_ready=1.
REQ-023 On i_ready=1 in DONE, the next state SHALL be IDLE; no operand is accepted in that same cycle.
REQ-024 Latency SHALL be measured from the accept edge k:
 - zero or Inf/NaN input: o_valid=1 after edge k.
 - carry or already-normal input: o_valid=1 after edge k+1.
 - n left shifts: o_valid=1 after edge k+1+n.
REQ-025 i_valid while not in IDLE SHALL be ignored.
REQ-026 i_ready outside DONE SHALL be ignored.
REQ-027 Flags SHALL be cleared on every acceptance.

Reset
REQ-028 Assertion of i_rst_n=0 SHALL immediately force IDLE, o_valid=0, o_ready=1 (once released), and all data outputs and flags to 0, including in the middle of SHIFT.
REQ-029 After reset release, the first operand SHALL be accepted on the first edge with i_valid=1.

Verification
REQ-030 Carry case: exp=0x80, mant=0x1800001 -> o_exp=0x81, o_mant=0x400000, o_inexact=1, o_valid one cycle after the accept edge.
REQ-031 Maximum shift: exp=0x80, mant=0x0000001 -> 23 SHIFT left cycles, o_exp=0x69, o_mant=0, o_valid after edge k+24.
REQ-032 Underflow: exp=0x02, mant=0x0100000 -> o_exp=0x00, o_mant=0x200000, o_underflow=1.
REQ-033 Overflow: exp=0xFE, mant=0x1800000 -> o_exp=0xFF, o_mant=0, o_overflow=1, o_inexact=0.
REQ-034 Handshake/zero: mant=0 with i_ready held 0 for 5 cycles -> o_valid and o_zero held stable, o_ready=0; on i_ready=1 -> IDLE next cycle.
REQ-035 Reset mid-SHIFT: assert i_rst_n=0 during the shift in REQ-031 -> o_valid=0 immediately; after release, o_ready=1 and the next operand processes correctly.
